// File: rtl/argmax_stream.sv
// argmax_stream: streaming arg-max over LANES scores per beat, registered winner and class index
module argmax_stream #(
    parameter int WORD_SIZE   = 16,
    parameter int IDX_SIZE    = 4,
    parameter int NUM_CLASSES = 10,
    parameter int LANES       = 2,
    parameter int SIGNED      = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*WORD_SIZE-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WORD_SIZE-1:0]       out_max,
    output logic [IDX_SIZE-1:0]        out_idx
);
    localparam int BEATS = (NUM_CLASSES + LANES - 1) / LANES;
    localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;

    typedef enum logic {ACCUM, DONE} state_t;

    state_t state, state_nxt;
    logic [BW-1:0] beat;
    logic [WORD_SIZE-1:0] run_max, bw_max, nxt_max;
    logic [IDX_SIZE-1:0] run_idx, bw_idx, nxt_idx;
    logic accept, last;

    function automatic logic gt(input logic [WORD_SIZE-1:0] a, input logic [WORD_SIZE-1:0] b);
        return (SIGNED != 0) ? ($signed(a) > $signed(b)) : (a > b);
    endfunction

    assign in_ready  = state == ACCUM;
    assign out_valid = state == DONE;
    assign accept    = in_valid && in_ready;
    assign last      = beat == BW'(BEATS - 1);

    // beat winner: lanes scanned upward with a strict compare so ties keep the lower index; padding lanes never compete
    always_comb begin
        bw_max = in_data[WORD_SIZE-1:0];
        bw_idx = IDX_SIZE'(int'(beat) * LANES);
        for (int k = 1; k < LANES; k++)
            if (int'(beat) * LANES + k < NUM_CLASSES && gt(in_data[k*WORD_SIZE +: WORD_SIZE], bw_max)) begin
                bw_max = in_data[k*WORD_SIZE +: WORD_SIZE];
                bw_idx = IDX_SIZE'(int'(beat) * LANES + k);
            end
        nxt_max = (beat == '0 || gt(bw_max, run_max)) ? bw_max : run_max;
        nxt_idx = (beat == '0 || gt(bw_max, run_max)) ? bw_idx : run_idx;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= ACCUM;
        else state <= state_nxt;

    // next state: flush wins, last beat completes a frame, handshake releases the result
    always_comb begin
        state_nxt = state;
        if (flush) state_nxt = ACCUM;
        else if (accept && last) state_nxt = DONE;
        else if (out_valid && out_ready) state_nxt = ACCUM;
    end

    // running max across beats; final beat publishes straight into the output registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            beat    <= '0;
            run_max <= '0;
            run_idx <= '0;
            out_max <= '0;
            out_idx <= '0;
        end else if (flush) begin
            beat <= '0;
        end else if (accept) begin
            run_max <= nxt_max;
            run_idx <= nxt_idx;
            beat    <= last ? '0 : beat + BW'(1);
            if (last) begin
                out_max <= nxt_max;
                out_idx <= nxt_idx;
            end
        end
endmodule

// File: tb/tb_argmax_stream.sv
// tb_argmax_stream: scoreboard bench for argmax_stream (signed N=10 and unsigned N=5 instances)
module tb_argmax_stream;
    typedef logic [15:0] sc_t [10];

    logic clk = 0, rst_n, flush;
    logic iv0, ir0, ov0, or0, iv1, ir1, ov1, or1;
    logic [31:0] id0, id1;
    logic [15:0] om0, om1;
    logic [3:0] oi0, oi1;
    logic [15:0] qm0[$], qm1[$];
    logic [3:0] qi0[$], qi1[$];
    int checks = 0, errors = 0;
    sc_t s;
    logic [19:0] r;

    always #5 clk = ~clk;

    argmax_stream d0 (.clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv0), .in_ready(ir0),
        .in_data(id0), .out_valid(ov0), .out_ready(or0), .out_max(om0), .out_idx(oi0));

    argmax_stream #(.NUM_CLASSES(5), .SIGNED(0)) d1 (.clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(iv1), .in_ready(ir1), .in_data(id1), .out_valid(ov1), .out_ready(or1),
        .out_max(om1), .out_idx(oi1));

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    function automatic logic [19:0] am(input sc_t v, input int n);
        logic [15:0] m = v[0];
        logic [3:0] ix = 0;
        for (int i = 1; i < n; i++)
            if ($signed(v[i]) > $signed(m)) begin
                m = v[i];
                ix = 4'(i);
            end
        return {ix, m};
    endfunction

    // monitors: pop the expected result on every output handshake
    always @(negedge clk)
        if (ov0 && or0) begin
            if (qm0.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut0_unexpected: got result %h/%0d, none expected", om0, oi0);
            end else begin
                chk("dut0_max", 32'(om0), 32'(qm0.pop_front()));
                chk("dut0_idx", 32'(oi0), 32'(qi0.pop_front()));
            end
        end

    always @(negedge clk)
        if (ov1 && or1) begin
            if (qm1.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut1_unexpected: got result %h/%0d, none expected", om1, oi1);
            end else begin
                chk("dut1_max", 32'(om1), 32'(qm1.pop_front()));
                chk("dut1_idx", 32'(oi1), 32'(qi1.pop_front()));
            end
        end

    task automatic put_beat(input int u, input logic [31:0] d);
        int t = 0;
        if (u == 0) begin iv0 = 1; id0 = d; end else begin iv1 = 1; id1 = d; end
        @(negedge clk);
        while (!(u == 0 ? ir0 : ir1) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            checks++; errors++;
            $display("FAIL in_ready_timeout dut%0d: in_ready stayed 0, required 1", u);
        end
        @(posedge clk); #1;
        if (u == 0) iv0 = 0; else iv1 = 0;
    endtask

    task automatic frame(input int u, input sc_t v, input bit gaps, input logic [15:0] em, input logic [3:0] ei);
        int n = (u == 0) ? 10 : 5;
        if (u == 0) begin qm0.push_back(em); qi0.push_back(ei); end
        else begin qm1.push_back(em); qi1.push_back(ei); end
        for (int b = 0; b < (n + 1) / 2; b++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
            put_beat(u, {v[2*b+1], v[2*b]});
        end
    endtask

    task automatic partial(input int n, input logic [31:0] d);
        for (int i = 0; i < n; i++) put_beat(0, d);
    endtask

    initial begin
        int t;
        rst_n = 0; flush = 0; iv0 = 0; iv1 = 0; id0 = 0; id1 = 0; or0 = 1; or1 = 1;
        repeat (3) @(posedge clk); #1;
        chk("rst_in_ready", 32'(ir0), 1);
        chk("rst_out_valid", 32'(ov0), 0);
        chk("rst_out_max", 32'(om0), 0);
        chk("rst_out_idx", 32'(oi0), 0);
        chk("rst_in_ready1", 32'(ir1), 1);
        rst_n = 1;
        @(posedge clk); #1;
        // mixed scores, tie between class 3 and 6 across beats
        s = '{16'd3, 16'd7, 16'hFFFE, 16'd9, 16'd1, 16'd0, 16'd9, 16'd4, 16'hFFF8, 16'd5};
        frame(0, s, 0, 16'd9, 4'd3);
        chk("latency_valid", 32'(ov0), 1);
        chk("done_in_ready", 32'(ir0), 0);
        @(posedge clk); #1;
        chk("valid_one_cycle", 32'(ov0), 0);
        chk("ready_after_done", 32'(ir0), 1);
        // all equal negatives: index 0
        s = '{default: 16'hFFFB};
        frame(0, s, 0, 16'hFFFB, 4'd0);
        @(posedge clk); #1;
        // unsigned instance: FFFF is the largest
        s = '{16'd1, 16'd1, 16'd1, 16'hFFFF, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        frame(1, s, 0, 16'hFFFF, 4'd3);
        @(posedge clk); #1;
        // padding lane carries FFFF but must be ignored
        s = '{16'd2, 16'd9, 16'd5, 16'd0, 16'd10, 16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0};
        frame(1, s, 0, 16'd10, 4'd4);
        @(posedge clk); #1;
        s = '{16'd7, 16'd3, 16'd3, 16'd7, 16'd7, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        frame(1, s, 0, 16'd7, 4'd0);
        @(posedge clk); #1;
        // back-pressure: result held stable for 6 cycles
        or0 = 0;
        s = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'h0100, 16'd9};
        frame(0, s, 0, 16'h0100, 4'd8);
        repeat (6) begin
            @(negedge clk);
            chk("bp_valid", 32'(ov0), 1);
            chk("bp_in_ready", 32'(ir0), 0);
            chk("bp_max", 32'(om0), 32'h0100);
            chk("bp_idx", 32'(oi0), 8);
        end
        @(posedge clk); #1;
        or0 = 1;
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(ov0), 0);
        chk("bp_release_ready", 32'(ir0), 1);
        s = '{default: 16'hFFFD};
        s[9] = 16'hFFFF;
        frame(0, s, 0, 16'hFFFF, 4'd9);
        @(posedge clk); #1;
        // flush after two beats
        partial(2, 32'h70007000);
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        chk("flush_valid", 32'(ov0), 0);
        chk("flush_ready", 32'(ir0), 1);
        frame(0, s, 0, 16'hFFFF, 4'd9);
        @(posedge clk); #1;
        // flush discards a pending result
        or0 = 0;
        partial(5, 32'h70007000);
        chk("pending_valid", 32'(ov0), 1);
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        chk("flush_pending_valid", 32'(ov0), 0);
        or0 = 1;
        // reset mid-frame
        partial(3, 32'h70007000);
        rst_n = 0;
        @(posedge clk); #1;
        chk("rst_mid_valid", 32'(ov0), 0);
        chk("rst_mid_ready", 32'(ir0), 1);
        rst_n = 1;
        @(posedge clk); #1;
        frame(0, s, 0, 16'hFFFF, 4'd9);
        // random frames with input gaps
        for (int f = 0; f < 200; f++) begin
            for (int i = 0; i < 10; i++) s[i] = 16'(int'($urandom_range(0, 15)) - 8);
            r = am(s, 10);
            frame(0, s, 1, r[15:0], r[19:16]);
        end
        t = 0;
        while ((qm0.size() != 0 || qm1.size() != 0) && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain", 32'(qm0.size() + qm1.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/argmax_stream.md
# argmax_stream

Streaming, parametrised arg-max unit for the FC output stage. It accepts classifier scores LANES at a time over a valid/ready stream and reduces each beat with a comparator tree. It keeps a running maximum and index across beats, then presents the winning score and its class index on a registered valid/ready output once all NUM_CLASSES scores have arrived. It replaces the single two-input comparator between the final FC layer and the result register.

## Interface
- WORD_SIZE, 16: score width in bits.
- IDX_SIZE, 4: class-index width; must satisfy 2^IDX_SIZE >= NUM_CLASSES.
- NUM_CLASSES, 10: scores per frame; must be >= 1.
- LANES, 2: scores per input beat; must be >= 1.
- SIGNED, 1: 1 selects two's-complement compare, 0 selects unsigned compare.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous frame abort.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  LANES*WORD_SIZE  packed scores; lane k sits at bits [k*WORD_SIZE +: WORD_SIZE].
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed.
- out_max  out  WORD_SIZE  winning score.
- out_idx  out  IDX_SIZE  winning class index.

## Operation
- BEATS = ceil(NUM_CLASSES/LANES). A beat counter `beat` counts 0..BEATS-1.
- Lane k of beat b carries class index b*LANES+k.
- In the last beat, lanes whose index is >= NUM_CLASSES are invalid. They never win and are ignored regardless of their data.
- Lane reduction is combinational over the valid lanes:
  - Comparison is a strict greater-than, signed or unsigned according to SIGNED.
  - On ties, the lower index wins, at every tree level and across beats.
- States:
  - ACCUM: in_ready=1.
    - Accepted beat with beat==0: the running max/index are loaded from the beat winner, with no comparison against stale state.
    - Accepted beat with beat>0: the running value is replaced only if the beat winner is strictly greater.
    - Accepting beat BEATS-1: the final winner is written to out_max/out_idx, out_valid is set, beat returns to 0, and the state goes to DONE.
  - DONE: in_ready=0 and out_valid=1; the outputs are held stable.
    - When out_valid && out_ready: out_valid falls and the state returns to ACCUM.
- flush (while rst_n is high):
  - Returns to ACCUM with beat=0 and out_valid=0, discarding any partial frame or pending result.
  - Takes priority over a simultaneous input beat or output handshake.
- Reset values:
  - State ACCUM, beat=0.
  - out_valid=0, out_max=0, out_idx=0, internal running max/index = 0.
  - in_ready therefore reads 1 once reset is applied.
- Reset mid-frame discards all partial state. The next accepted beat is treated as beat 0.
- NUM_CLASSES=1 or BEATS=1: every accepted beat completes a frame.

## Timing
- A beat is accepted on a rising edge where in_valid && in_ready.
- The result is registered. out_valid rises in the cycle after the final beat is accepted, which is 1-cycle latency.
- Throughput:
  - One beat per cycle within a frame.
  - One idle input cycle per frame, because the DONE state lasts at least one cycle.
  - DONE lasts longer if out_ready is low.
- in_ready is a function of state only, with no combinational path from out_ready. out_max, out_idx and out_valid come directly from registers.
- While out_valid=1 and out_ready=0, out_max and out_idx must not change.

## Test plan
- Defaults (N=10, L=2, signed). Scores 3,7,-2,9,1,0,9,4,-8,5 in 5 beats with out_ready=1 -> out_max=9, out_idx=3 (tie with class 6; lower index wins), out_valid for exactly 1 cycle, 1 cycle after the last beat.
- Defaults, all scores -5 -> out_max=-5, out_idx=0. Repeat with SIGNED=0 and scores 16'hFFFF at class 8, others 1 -> out_max=16'hFFFF, out_idx=8.
- N=5, L=2. Last beat lanes = {4:10, 5(invalid):32767}, earlier scores < 10 -> out_idx=4 and out_max=10; the invalid lane is ignored.
- Back-pressure. Hold out_ready=0 for 6 cycles after completion -> in_ready=0 and outputs stable throughout. Raise out_ready -> out_valid drops next edge and in_ready=1; a following frame is then processed correctly with no stale max carried over.
- Random in_valid gaps (~50%) over 200 frames, compared against a scoreboard argmax with lowest-index tie-break -> all results match.
- Assert flush after beat 2, and separately deassert rst_n mid-frame -> out_valid=0. The next full frame, e.g. max -1 at class 9 with all others -3, gives out_max=-1, out_idx=9; no contamination from the aborted data.
